fw_log_capture: RTL and testbench

FW_LOG_CAPTURE -- requirements
Module: fw_log_capture

---
 rtl/fw_log_pkg.sv | 19 +
 rtl/fw_log_fifo_core.sv | 51 +++++
 rtl/fw_log_capture.sv | 114 +++++++++++
 tb/tb_fw_log_capture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_log_pkg.sv
// Shared types and widths for the firmware log capture block.
package fw_log_pkg;

    localparam int SEQ_W      = 16;
    localparam int CNT_W      = 16;
    localparam int LOG_DATA_W = 32;

    typedef struct packed {
        logic [SEQ_W-1:0]      seq;
        logic [LOG_DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/fw_log_fifo_core.sv
// Synchronous first-word-fall-through FIFO; clear wins over push/pop.
module fw_log_fifo_core
    import fw_log_pkg::*;
#(
    parameter int WIDTH = $bits(entry_t),
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Power-of-two depth: pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fw_log_capture.sv
// Snoops SRAM writes to one address and queues {seq, data} for a log consumer.
//   state     | meaning
//   ST_IDLE   | FIFO empty, log_valid low
//   ST_STREAM | FIFO holds words, log_valid high
//   ST_FLUSH  | one-cycle clear, hits discarded
module fw_log_capture
    import fw_log_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 14,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 'h0000,
    parameter int                    DEPTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_en,
    input  logic                   flush,
    input  logic                   enable,
    input  logic                   write,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic                   log_valid,
    input  logic                   log_ready,
    output logic [DATA_WIDTH-1:0]  log_data,
    output logic [SEQ_W-1:0]       log_seq,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int ENTRY_W = SEQ_W + DATA_WIDTH;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    state_t             state;
    state_t             state_next;
    logic [SEQ_W-1:0]   seq;
    logic               hit;
    logic               pop;
    logic               push;
    logic               drop;
    logic               clear_fifo;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] rd_entry;

    assign hit  = cap_en & ~enable & ~write & (address == TARGET_ADDR);
    assign pop  = log_valid & log_ready & ~empty;
    assign push = hit & ~clear_fifo & (~full | pop);
    assign drop = hit & ~clear_fifo & full & ~pop;

    fw_log_fifo_core #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .clear   (clear_fifo),
        .wr_data ({seq, data_in}),
        .rd_data (rd_entry),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // Storage is unreset, so outputs are forced to zero whenever nothing is valid.
    assign {log_seq, log_data} = log_valid ? rd_entry : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:   if (push) state_next = ST_STREAM;
                ST_STREAM: if (pop && !push && level == LVL_W'(1)) state_next = ST_IDLE;
                ST_FLUSH:  state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        log_valid  = 1'b0;
        clear_fifo = flush;
        case (state)
            ST_STREAM: log_valid  = 1'b1;
            ST_FLUSH:  clear_fifo = 1'b1;
            default:   ;
        endcase
    end

    // Sequence advances on every hit, including dropped and discarded ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (hit) seq <= seq + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fw_log_capture.sv
// Directed plus random checks of fw_log_capture against a queue-based reference model.
module tb_fw_log_capture;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam logic [AW-1:0] TGT = 14'h0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_en;
    logic          flush;
    logic          enable;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic          log_valid;
    logic          log_ready;
    logic [DW-1:0] log_data;
    logic [15:0]   log_seq;
    logic [4:0]    level;
    logic          overflow;
    logic [15:0]   drop_cnt;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] data;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    ent_t        obs_pops[$];
    logic [15:0] m_seq;
    logic [15:0] m_drop;
    bit          m_ovf;
    bit          m_fl;
    bit          saw_wrap;
    bit          have_last;
    logic [15:0] last_pop_seq;

    fw_log_capture #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TARGET_ADDR (TGT),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .flush     (flush),
        .enable    (enable),
        .write     (write),
        .address   (address),
        .data_in   (data_in),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_data  (log_data),
        .log_seq   (log_seq),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: pop the head, then accept or drop the hit, then apply flush.
    task automatic model_step();
        bit hit;
        bit pop;
        bit discard;
        if (rst) begin
            q.delete();
            m_seq  = '0;
            m_drop = '0;
            m_ovf  = 1'b0;
            m_fl   = 1'b0;
            return;
        end
        hit     = cap_en && !enable && !write && (address == TGT);
        pop     = (q.size() > 0) && log_ready;
        discard = flush || m_fl;
        if (pop) void'(q.pop_front());
        if (hit && !discard) begin
            if (q.size() < DEPTH) begin
                q.push_back({m_seq, data_in});
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
        if (flush) q.delete();
        m_fl = flush;
        if (hit) m_seq = m_seq + 16'd1;
    endtask

    task automatic check_all();
        chk("log_valid", 32'(log_valid), 32'(q.size() > 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (q.size() > 0) begin
            chk("log_data", log_data, q[0].data);
            chk("log_seq", 32'(log_seq), 32'(q[0].seq));
        end
    endtask

    // Handshake is sampled mid-cycle, then the edge, then outputs 1ns later.
    task automatic tick();
        if (log_valid === 1'b1 && log_ready === 1'b1) begin
            obs_pops.push_back({log_seq, log_data});
            if (have_last && last_pop_seq == 16'hFFFF && log_seq == 16'h0000) saw_wrap = 1'b1;
            last_pop_seq = log_seq;
            have_last    = 1'b1;
        end
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic hit_cyc(input logic [AW-1:0] a, input logic [31:0] d);
        enable  = 1'b0;
        write   = 1'b0;
        address = a;
        data_in = d;
        tick();
        enable  = 1'b1;
        write   = 1'b1;
        address = TGT;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cap_en = 1'b0; flush = 1'b0; enable = 1'b1; write = 1'b1;
        address = TGT; data_in = '0; log_ready = 1'b0;
        m_seq = '0; m_drop = '0; m_ovf = 1'b0; m_fl = 1'b0;
        saw_wrap = 1'b0; have_last = 1'b0; last_pop_seq = '0;

        repeat (3) tick();
        chk("rst_log_data", log_data, 32'h0);
        chk("rst_log_seq", 32'(log_seq), 32'h0);
        rst = 1'b0;

        // Three in-order captures drained immediately.
        cap_en = 1'b1; log_ready = 1'b1;
        for (int i = 0; i < 3; i++) hit_cyc(TGT, 32'hA5A5_0001 + 32'(i));
        repeat (3) tick();
        chk("basic_pop_count", 32'(obs_pops.size()), 32'd3);
        for (int i = 0; i < 3 && i < obs_pops.size(); i++) begin
            chk("basic_seq", 32'(obs_pops[i].seq), 32'(i));
            chk("basic_data", obs_pops[i].data, 32'hA5A5_0001 + 32'(i));
        end
        chk("basic_overflow", 32'(overflow), 32'd0);

        // Neighbour-address write and a read do not capture.
        hit_cyc(TGT + 14'd1, 32'h1111_2222);
        enable = 1'b0; write = 1'b1; tick(); enable = 1'b1;
        chk("nohit_level", 32'(level), 32'd0);
        log_ready = 1'b0;
        hit_cyc(TGT, 32'h3333_4444);
        chk("nohit_seq", 32'(log_seq), 32'd3);
        log_ready = 1'b1;
        repeat (2) tick();

        // Overflow: 18 hits into a 16-deep FIFO.
        do_reset();
        log_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) hit_cyc(TGT, $urandom);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        obs_pops.delete();
        log_ready = 1'b1;
        repeat (DEPTH) tick();
        log_ready = 1'b0;
        chk("ovf_drain_count", 32'(obs_pops.size()), 32'd16);
        for (int i = 0; i < obs_pops.size(); i++) chk("ovf_drain_seq", 32'(obs_pops[i].seq), 32'(i));
        hit_cyc(TGT, 32'hCAFE_0018);
        chk("ovf_next_seq", 32'(log_seq), 32'd18);

        // Full FIFO, push and pop together.
        for (int i = 0; i < DEPTH - 1; i++) hit_cyc(TGT, $urandom);
        chk("full_level", 32'(level), 32'd16);
        log_ready = 1'b1;
        hit_cyc(TGT, 32'hBEEF_0001);
        log_ready = 1'b0;
        chk("full_pushpop_level", 32'(level), 32'd16);
        chk("full_pushpop_drop", 32'(drop_cnt), 32'd2);
        log_ready = 1'b1;
        repeat (DEPTH + 2) tick();

        // Flush together with a hit.
        do_reset();
        log_ready = 1'b0;
        for (int i = 0; i < 5; i++) hit_cyc(TGT, $urandom);
        flush = 1'b1;
        hit_cyc(TGT, 32'hDEAD_0005);
        flush = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(log_valid), 32'd0);
        tick();
        hit_cyc(TGT, 32'hDEAD_0006);
        chk("flush_next_seq", 32'(log_seq), 32'd6);
        chk("flush_drop_cnt", 32'(drop_cnt), 32'd0);

        // Random traffic with bursty back-pressure, flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            flush  = ($urandom_range(0, 39) == 0);
            cap_en = ($urandom_range(0, 9) != 0);
            enable = ($urandom_range(0, 3) == 0);
            write  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       address = TGT + 14'd1;
                1:       address = AW'($urandom);
                default: address = TGT;
            endcase
            data_in   = $urandom;
            log_ready = ($urandom_range(0, 99) < (((i / 250) % 2) != 0 ? 70 : 5));
            tick();
        end
        rst = 1'b0; flush = 1'b0; enable = 1'b1; write = 1'b1; address = TGT;

        // Long run to wrap the sequence counter.
        do_reset();
        cap_en = 1'b1; log_ready = 1'b1;
        obs_pops.delete();
        have_last = 1'b0;
        saw_wrap  = 1'b0;
        enable = 1'b0; write = 1'b0; address = TGT;
        for (int i = 0; i < 70000; i++) begin
            data_in = $urandom;
            tick();
        end
        enable = 1'b1; write = 1'b1;
        repeat (2) tick();
        chk("wrap_seen", 32'(saw_wrap), 32'd1);
        chk("wrap_pop_count", 32'(obs_pops.size()), 32'd70000);
        chk("wrap_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("wrap_overflow", 32'(overflow), 32'd0);
        chk("wrap_level", 32'(level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
